// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmit FSM encoding, frame-length helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    // Number of bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data (head visible on o_rd_data).
// Latency: a write is visible at the head one cycle after the write edge.
// Backpressure: writes are dropped while full (even with a same-cycle read); reads ignored while empty.
//
// Ports: i_clk, i_rst_n (sync, active-low), i_wr_en/i_wr_data, i_rd_en/o_rd_data,
//        o_full, o_empty, o_count (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Full is judged on the current count, so a read in the same cycle does not open a slot.
    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; queued words are sent back-to-back with no idle gap.
// Latency: word pushed into an empty FIFO at edge N drives the start bit from edge N+1.
// Backpressure: in_ready = not-full; a push while full is refused even if a pop coincides.
//
// Ports: clk, rst (sync, active-low), in_valid/in_ready/in_data (push side),
//        tx (serial line, idles high), busy, frame_done (pulse on last clk of frame),
//        fifo_count (queued words, frame in flight excluded).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);

    tx_state_t              r_state;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_idx;     // data bit index in DATA, stop bit index in STOP
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_full;
    logic                   w_empty;
    logic [DATA_BITS-1:0]   w_rd_data;
    logic                   w_bit_end;
    logic                   w_pop;

    assign w_bit_end = (r_cnt == CNT_LAST);

    // Pop from IDLE on any edge with data, or at the very end of the last stop bit to chain.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) ||
                    (r_state == S_STOP && w_bit_end && r_idx == LAST_STOP));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_wr_en   (in_valid),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (fifo_count)
    );

    assign in_ready   = !w_full;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Baud divider restarts on every bit boundary, i.e. on every state entry.
            if (r_state != S_IDLE) r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_START;
                        r_shift <= w_rd_data;
                        r_par   <= (^w_rd_data) ^ (PARITY == PAR_ODD);
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == LAST_DATA) begin
                            if (PARITY != PAR_NONE) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_idx   <= '0;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            // LSB first: the next bit is always one above the current head.
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_idx   <= '0;
                        r_tx    <= 1'b1;
                    end
                end

                S_STOP: begin
                    // Registered pulse: raise it one cycle early so it lands on the final clk.
                    if (r_idx == LAST_STOP && r_cnt == CNT_PENULT) r_done <= 1'b1;
                    if (w_bit_end) begin
                        if (r_idx != LAST_STOP) begin
                            r_idx <= r_idx + 1'b1;
                        end else if (w_pop) begin
                            r_state <= S_START;
                            r_shift <= w_rd_data;
                            r_par   <= (^w_rd_data) ^ (PARITY == PAR_ODD);
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
